// File: rtl/mux_pkg.sv
// Shared constants for the arb_sel_mux codebase slice.
// Holds the encoding of the mode input.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// Round-robin search over NUM_IN valid bits starting at ptr, wrapping at
// NUM_IN-1 -> 0. Produces a one-hot grant, the granted index and an any flag.
// Used by arb_sel_mux only when ARB_SEL_MUX_RR_EN is defined.
module rr_arbiter #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] valid,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_any
);

    // First valid channel at or above ptr, modulo NUM_IN.
    always_comb begin
        int unsigned cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_IN; off++) begin
            cand = (32'(ptr) + off) % NUM_IN;
            if (!grant_any && valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = SEL_W'(cand);
                grant_any   = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/arb_sel_mux.sv
// Channel selector with registered valid/ready output stage.
// Fixed mode grants channel sel; round-robin mode (only when the macro
// ARB_SEL_MUX_RR_EN is defined) rotates a search pointer after each transfer.
// Without ARB_SEL_MUX_RR_EN the mode input is ignored and no pointer exists.
module arb_sel_mux
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [NUM_IN-1:0] fix_grant;
    logic [SEL_W-1:0]  fix_idx;
    logic              fix_any;

    logic [NUM_IN-1:0] grant_vec;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;

    logic              can_load;
    logic              xfer;

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;
    logic              out_valid_q, out_valid_d;

    // Fixed select: sel values with no matching channel never grant.
    always_comb begin
        fix_grant = '0;
        fix_idx   = '0;
        fix_any   = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                fix_grant[i] = 1'b1;
                fix_idx      = SEL_W'(i);
                fix_any      = 1'b1;
            end
        end
    end

`ifdef ARB_SEL_MUX_RR_EN
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [NUM_IN-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_any;
    logic              use_rr;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr (
        .valid     (in_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .grant_any (rr_any)
    );

    assign use_rr = (mode == MODE_RR);

    // Pick the active arbitration source.
    always_comb begin
        if (use_rr) begin
            grant_vec = rr_grant;
            grant_idx = rr_idx;
            grant_any = rr_any;
        end else begin
            grant_vec = fix_grant;
            grant_idx = fix_idx;
            grant_any = fix_any;
        end
    end

    // Pointer moves past the winner only on a round-robin transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer && use_rr) begin
            ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Fixed select is the only arbitration source.
    always_comb begin
        grant_vec = fix_grant;
        grant_idx = fix_idx;
        grant_any = fix_any;
    end
`endif

    // Handshake and next output state; a transfer overrides the drain.
    always_comb begin
        can_load    = !out_valid_q || out_ready;
        xfer        = grant_any && can_load && !rst;
        in_ready    = xfer ? grant_vec : '0;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = in_data[grant_idx*WIDTH +: WIDTH];
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule : arb_sel_mux

// File: tb/tb_arb_sel_mux.sv
// Self-checking bench for arb_sel_mux (4 channels x 32 bits, 3-bit select
// so that out-of-range select values can be driven).
module tb_arb_sel_mux;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 3;
`ifdef ARB_SEL_MUX_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_valid;
    logic            out_ready;

    int total = 0;
    int bad   = 0;

    arb_sel_mux #(
        .WIDTH  (W),
        .NUM_IN (N),
        .SEL_W  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what the output stage must hold after each edge.
    bit          model_ok = 1'b0;
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_src;
    int          m_ptr;

    always @(negedge clk) begin : cmp
        bit       can_ld, g_any, eff_rr;
        int       g, c;
        logic [N-1:0] exp_rdy;
        g_any   = 1'b0;
        g       = 0;
        exp_rdy = '0;
        if (model_ok) begin
            chk("m_out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("m_out_data", out_data, m_data);
                chk("m_out_src", out_src, m_src);
            end
        end
        can_ld = !m_valid || out_ready;
        eff_rr = RR_BUILD && mode;
        if (eff_rr) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!g_any && in_valid[c]) begin
                    g_any = 1'b1;
                    g     = c;
                end
            end
        end else if (int'(sel) < N) begin
            if (in_valid[sel]) begin
                g_any = 1'b1;
                g     = int'(sel);
            end
        end
        if (!rst && model_ok && g_any && can_ld) exp_rdy[g] = 1'b1;
        if (model_ok || rst) chk("m_in_ready", in_ready, exp_rdy);
        if (rst) begin
            m_valid  = 1'b0;
            m_data   = '0;
            m_src    = 0;
            m_ptr    = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (g_any && can_ld) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_src   = g;
                if (eff_rr) m_ptr = (g + 1) % N;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_data(input int tag);
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h1000_0000 * (i + 1) + tag;
    endtask

    int        exp_seq[5];
    logic [3:0] tv_valid[12] = '{4'hF, 4'b1010, 4'b0001, 4'b0000, 4'b1000, 4'b0110,
                                 4'hF, 4'b0101, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    logic [2:0] tv_sel[12]   = '{3'd0, 3'd3, 3'd0, 3'd1, 3'd3, 3'd2,
                                 3'd7, 3'd2, 3'd4, 3'd1, 3'd3, 3'd1};
    logic       tv_mode[12]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       tv_ordy[12]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_src", out_src, 3'd0);
        rst = 1'b0;

        // Fixed select of channel 2.
        fill_data(0);
        in_data[2*W +: W] = 32'hDEAD_BEEF;
        mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; out_ready = 1'b1;
        #2 chk("fix_in_ready", in_ready, 4'b0100);
        cyc();
        chk("fix_out_valid", out_valid, 1'b1);
        chk("fix_out_data", out_data, 32'hDEAD_BEEF);
        chk("fix_out_src", out_src, 3'd2);
        // Drain with no grant: valid clears, data holds.
        in_valid = 4'b0000;
        cyc();
        chk("drain_out_valid", out_valid, 1'b0);
        chk("drain_out_data", out_data, 32'hDEAD_BEEF);

        // Out-of-range select never grants.
        sel = 3'd5; in_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #2 chk("oor_in_ready", in_ready, 4'b0000);
            cyc();
            chk("oor_out_valid", out_valid, 1'b0);
        end

        // Load channel 1, then stall three cycles with changing inputs.
        fill_data(0);
        in_data[1*W +: W] = 32'h1111_0001;
        sel = 3'd1; out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fill_data(k + 7);
            sel = 3'(k);
            mode = k[0];
            #2 chk("stall_in_ready", in_ready, 4'b0000);
            cyc();
            chk("stall_out_data", out_data, 32'h1111_0001);
            chk("stall_out_src", out_src, 3'd1);
            chk("stall_out_valid", out_valid, 1'b1);
        end

        // Back-to-back replacement in fixed mode.
        mode = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fill_data(k + 32);
            sel = 3'(3 - k);
            cyc();
        end
        chk("b2b_out_src", out_src, 3'd0);
        chk("b2b_out_data", out_data, 32'h1000_0000 + 35);

        // Mode=1, sel=1, all valid: rotate when round-robin is built, else stick to 1.
        if (RR_BUILD) exp_seq = '{0, 1, 2, 3, 0};
        else          exp_seq = '{1, 1, 1, 1, 1};
        mode = 1'b1; sel = 3'd1; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fill_data(k + 64);
            cyc();
            chk("rr_seq_src", out_src, 3'(exp_seq[k]));
        end

        // Push pointer to 3 with output held, then reset.
        in_valid = 4'b0100;
        cyc();
        out_ready = 1'b0; in_valid = 4'hF;
        cyc();
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        cyc();
        chk("post_rst_valid", out_valid, 1'b0);
        chk("post_rst_data", out_data, 32'h0);
        rst = 1'b0; mode = 1'b1; sel = 3'd0; out_ready = 1'b1;
        cyc();
        chk("post_rst_src", out_src, 3'd0);

        // Mixed directed vectors, checked by the model each cycle.
        for (int k = 0; k < 12; k++) begin
            fill_data(k + 128);
            in_valid  = tv_valid[k];
            sel       = tv_sel[k];
            mode      = tv_mode[k];
            out_ready = tv_ordy[k];
            cyc();
        end
        in_valid = '0; out_ready = 1'b1;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_arb_sel_mux

// File: doc/arb_sel_mux.md
ARB_SEL_MUX -- requirements
Module: arb_sel_mux

Interface
REQ-001 Parameter WIDTH, default 32, data bits per input channel.
REQ-002 Parameter NUM_IN, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), channel-index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready; combinational.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  input  SEL_W  channel index used in fixed mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_src  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  registered output valid.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 Output register "can load" = !out_valid || out_ready.
REQ-016 Fixed mode: grant = sel when sel < NUM_IN and in_valid[sel]=1; otherwise no grant; sel >= NUM_IN never grants.
REQ-017 Round-robin mode: grant = first channel with in_valid=1 searching upward from ptr with wrap at NUM_IN-1 -> 0; no grant if all in_valid=0.
REQ-018 in_ready[g]=1 only for granted channel g and only when can load; all other in_ready bits 0.
REQ-019 Transfer on channel g when in_valid[g] && in_ready[g]; next cycle out_data=in_data channel g, out_src=g, out_valid=1 (latency 1 cycle, throughput 1 per cycle).
REQ-020 Stall: out_valid=1 && out_ready=0 -> out_data, out_src, out_valid held stable; all in_ready=0.
REQ-021 out_valid && out_ready with no grant -> out_valid clears next cycle; out_data/out_src hold last value.
REQ-022 ptr (SEL_W bits) updates only on a round-robin transfer: ptr <= (g == NUM_IN-1) ? 0 : g+1; unchanged in fixed mode and on no transfer.
REQ-023 mode or sel change while out_valid=1 does not alter held output; new setting governs the next grant only.
REQ-024 Simultaneous out_ready=1 and new transfer -> output replaced in the same edge, no bubble.

Reset
REQ-025 rst=1 at a clock edge -> out_valid=0, out_data=0, out_src=0, ptr=0; in_ready all 0 during reset.
REQ-026 rst mid-operation discards any held output without handshake; first grant after reset starts search at channel 0.

Configuration
REQ-027 Macro ARB_SEL_MUX_RR_EN defined: round-robin mode and ptr are implemented per REQ-017/REQ-022.
REQ-028 Macro undefined: mode input ignored, block always behaves as fixed select, ptr not implemented; all other behaviour identical.

Structure
REQ-029 Shared package mux_pkg holds mode constants MODE_FIXED=1'b0, MODE_RR=1'b1 and the clog2 helper if not built-in.
REQ-030 One sub-module rr_arbiter (NUM_IN valid bits + ptr -> one-hot grant and index) is instantiated only under ARB_SEL_MUX_RR_EN.

Verification
REQ-031 Fixed mode, sel=2, in_valid=4'b0100, data2=32'hDEAD_BEEF, out_ready=1 -> next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_src=2, in_ready was 4'b0100.
REQ-032 Round-robin, all in_valid=1 for 5 cycles, out_ready=1 -> out_src sequence 0,1,2,3,0.
REQ-033 Stall: out_valid=1, out_ready=0 for 3 cycles, inputs changing -> out_data constant, in_ready=0 all 3 cycles.
REQ-034 Fixed mode sel=5 with NUM_IN=4, all valid -> in_ready=0, out_valid stays 0.
REQ-035 rst=1 while out_valid=1, ptr=3 -> next cycle out_valid=0, out_data=0, first RR grant with all valid is channel 0.
REQ-036 Build without ARB_SEL_MUX_RR_EN, mode=1, sel=1, all valid -> only channel 1 granted every cycle.
